full_adder_seq: RTL and testbench

FULL_ADDER_SEQ -- requirements
Module: full_adder_seq

---
 rtl/full_adder_seq.sv | 226 ++++++++++++++++++++++
 tb/tb_full_adder_seq.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/full_adder_seq.sv
`default_nettype none
// ============================================================================
// Module   : full_adder_seq
// Desc     : Bit-serial adder that drives an external asynchronous dual-rail
//            full-adder cell using a four-phase or two-phase handshake.
// Revision : 1.0 - initial release
// ============================================================================
module full_adder_seq #(
    parameter int WIDTH   = 8,
    parameter     ENC     = "FP",
    parameter int EN_CYC  = 2,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             err,
    output logic             fa_rst,
    output logic             fa_en,
    output logic [1:0]       fa_a,
    output logic [1:0]       fa_b,
    output logic [1:0]       fa_cin,
    input  logic [1:0]       fa_s,
    input  logic [1:0]       fa_cout
);

    localparam bit c_is_tp = (ENC == "TP");

    generate
        if (ENC != "FP" && ENC != "TP") begin : g_bad_enc
            $error("full_adder_seq: ENC must be FP or TP");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRIVE = 3'd1,
        EN_HI = 3'd2,
        WAIT  = 3'd3,
        RTZ   = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t           r_state;
    logic             r_in_ready, r_out_valid, r_c_out, r_err;
    logic             r_fa_rst, r_fa_en, r_carry;
    logic [WIDTH-1:0] r_a, r_b, r_mask, r_sum;
    logic [1:0]       r_fa_a, r_fa_b, r_fa_cin;
    logic [1:0]       r_s_meta, r_s_sync, r_c_meta, r_c_sync;
    logic [1:0]       r_last_s, r_last_c;
    logic [31:0]      r_en_cnt, r_tmr;

    // FP sends the codeword itself; TP toggles the rail selected by the value.
    function automatic logic [1:0] f_rail(input logic [1:0] cur, input logic v);
        logic [1:0] w_code;
        w_code = v ? 2'b10 : 2'b01;
        return c_is_tp ? (cur ^ w_code) : w_code;
    endfunction

    logic [1:0]       w_s_code, w_c_code;
    logic             w_valid, w_illegal, w_rtz_done, w_tmo, w_last, w_abort;
    logic             w_next_carry;
    logic [WIDTH-1:0] w_a_nxt, w_b_nxt;

    assign w_s_code     = c_is_tp ? (r_s_sync ^ r_last_s) : r_s_sync;
    assign w_c_code     = c_is_tp ? (r_c_sync ^ r_last_c) : r_c_sync;
    assign w_valid      = (w_s_code == 2'b01 || w_s_code == 2'b10) &&
                          (w_c_code == 2'b01 || w_c_code == 2'b10);
    assign w_illegal    = !c_is_tp && (r_s_sync == 2'b11 || r_c_sync == 2'b11);
    assign w_rtz_done   = (r_s_sync == 2'b00) && (r_c_sync == 2'b00);
    assign w_tmo        = (r_tmr == 32'(TIMEOUT - 1));
    assign w_last       = r_mask[WIDTH-1];
    assign w_next_carry = (r_state == WAIT) ? w_code_carry() : r_carry;
    assign w_a_nxt      = r_a >> 1;
    assign w_b_nxt      = r_b >> 1;

    function automatic logic w_code_carry();
        return w_c_code[1];
    endfunction

    assign w_abort = ((r_state == WAIT) && (w_illegal || (!w_valid && w_tmo))) ||
                     ((r_state == RTZ)  && (w_illegal || (!w_rtz_done && w_tmo)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_c_out     <= 1'b0;
            r_err       <= 1'b0;
            r_fa_rst    <= 1'b1;
            r_fa_en     <= 1'b0;
            r_fa_a      <= 2'b00;
            r_fa_b      <= 2'b00;
            r_fa_cin    <= 2'b00;
            r_s_meta    <= 2'b00;
            r_s_sync    <= 2'b00;
            r_c_meta    <= 2'b00;
            r_c_sync    <= 2'b00;
            r_last_s    <= 2'b00;
            r_last_c    <= 2'b00;
            r_a         <= '0;
            r_b         <= '0;
            r_mask      <= '0;
            r_carry     <= 1'b0;
            r_en_cnt    <= '0;
            r_tmr       <= '0;
        end else begin
            r_s_meta <= fa_s;
            r_s_sync <= r_s_meta;
            r_c_meta <= fa_cout;
            r_c_sync <= r_c_meta;
            r_fa_rst <= 1'b0;

            if (w_abort) begin
                // Bits already written stay; the rest were cleared at accept.
                r_err       <= 1'b1;
                r_c_out     <= 1'b0;
                r_fa_rst    <= 1'b1;
                r_fa_a      <= 2'b00;
                r_fa_b      <= 2'b00;
                r_fa_cin    <= 2'b00;
                r_last_s    <= 2'b00;
                r_last_c    <= 2'b00;
                r_out_valid <= 1'b1;
                r_state     <= DONE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (!r_in_ready) begin
                            r_in_ready <= 1'b1;
                        end else if (in_valid) begin
                            r_in_ready <= 1'b0;
                            r_a        <= op_a;
                            r_b        <= op_b;
                            r_carry    <= c_in;
                            r_mask     <= WIDTH'(1);
                            r_sum      <= '0;
                            r_c_out    <= 1'b0;
                            r_err      <= 1'b0;
                            r_fa_a     <= f_rail(r_fa_a, op_a[0]);
                            r_fa_b     <= f_rail(r_fa_b, op_b[0]);
                            r_fa_cin   <= f_rail(r_fa_cin, c_in);
                            r_state    <= DRIVE;
                        end
                    end
                    DRIVE: begin
                        r_fa_en  <= 1'b1;
                        r_en_cnt <= '0;
                        r_state  <= EN_HI;
                    end
                    EN_HI: begin
                        if (r_en_cnt == 32'(EN_CYC - 1)) begin
                            r_fa_en <= 1'b0;
                            r_tmr   <= '0;
                            r_state <= WAIT;
                        end else begin
                            r_en_cnt <= r_en_cnt + 32'd1;
                        end
                    end
                    WAIT, RTZ: begin
                        r_tmr <= r_tmr + 32'd1;
                        if (r_state == WAIT && w_valid) begin
                            r_sum    <= r_sum | (w_s_code[1] ? r_mask : '0);
                            r_carry  <= w_c_code[1];
                            r_last_s <= r_s_sync;
                            r_last_c <= r_c_sync;
                            if (!c_is_tp) begin
                                r_fa_a   <= 2'b00;
                                r_fa_b   <= 2'b00;
                                r_fa_cin <= 2'b00;
                                r_state  <= RTZ;
                            end
                        end
                        if ((r_state == WAIT && w_valid && c_is_tp) ||
                            (r_state == RTZ && w_rtz_done)) begin
                            if (w_last) begin
                                r_c_out     <= w_next_carry;
                                r_out_valid <= 1'b1;
                                r_state     <= DONE;
                            end else begin
                                r_mask   <= r_mask << 1;
                                r_a      <= w_a_nxt;
                                r_b      <= w_b_nxt;
                                r_fa_a   <= f_rail(r_fa_a, w_a_nxt[0]);
                                r_fa_b   <= f_rail(r_fa_b, w_b_nxt[0]);
                                r_fa_cin <= f_rail(r_fa_cin, w_next_carry);
                                r_state  <= DRIVE;
                            end
                        end
                    end
                    DONE: begin
                        if (out_ready) begin
                            r_out_valid <= 1'b0;
                            r_in_ready  <= 1'b1;
                            r_state     <= IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign c_out     = r_c_out;
    assign err       = r_err;
    assign fa_rst    = r_fa_rst;
    assign fa_en     = r_fa_en;
    assign fa_a      = r_fa_a;
    assign fa_b      = r_fa_b;
    assign fa_cin    = r_fa_cin;

endmodule
`default_nettype wire

// File: tb/tb_full_adder_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_full_adder_seq
// Desc     : Runs an FP and a TP instance side by side against behavioral
//            dual-rail full-adder cells and checks results vector by vector.
// Revision : 1.0 - initial release
// ============================================================================
module tb_full_adder_seq;

    localparam int WIDTH   = 4;
    localparam int EN_CYC  = 2;
    localparam int TIMEOUT = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] op_a = '0, op_b = '0;
    logic             c_in = 1'b0;

    logic             in_ready [2];
    logic             out_valid [2];
    logic [WIDTH-1:0] sum [2];
    logic             c_out [2];
    logic             err [2];
    logic             fa_rst [2];
    logic             fa_en [2];
    logic [1:0]       fa_a [2];
    logic [1:0]       fa_b [2];
    logic [1:0]       fa_cin [2];
    logic [1:0]       fa_s [2]    = '{2'b00, 2'b00};
    logic [1:0]       fa_cout [2] = '{2'b00, 2'b00};

    for (genvar g = 0; g < 2; g++) begin : g_dut
        full_adder_seq #(
            .WIDTH(WIDTH), .ENC(g == 0 ? "FP" : "TP"),
            .EN_CYC(EN_CYC), .TIMEOUT(TIMEOUT)
        ) u_dut (
            .clk(clk), .rst_n(rst_n),
            .in_valid(in_valid), .in_ready(in_ready[g]),
            .op_a(op_a), .op_b(op_b), .c_in(c_in),
            .out_valid(out_valid[g]), .out_ready(out_ready),
            .sum(sum[g]), .c_out(c_out[g]), .err(err[g]),
            .fa_rst(fa_rst[g]), .fa_en(fa_en[g]),
            .fa_a(fa_a[g]), .fa_b(fa_b[g]), .fa_cin(fa_cin[g]),
            .fa_s(fa_s[g]), .fa_cout(fa_cout[g])
        );
    end

    // Adder cell controls and observation counters (index 0 = FP, 1 = TP)
    int         stall_at [2] = '{-1, -1};
    logic       bad11 [2]    = '{1'b0, 1'b0};
    int         nbits [2]    = '{0, 0};
    logic [1:0] la [2] = '{2'b00, 2'b00}, lb [2] = '{2'b00, 2'b00}, lc [2] = '{2'b00, 2'b00};
    int         cyc = 0;
    logic       en_prev [2] = '{1'b0, 1'b0}, ov_prev [2] = '{1'b0, 1'b0};
    int         en_run [2] = '{0, 0}, en_pulses [2] = '{0, 0}, en_bad [2] = '{0, 0};
    int         rst_hi [2] = '{0, 0}, fall_cyc [2] = '{0, 0}, ov_cyc [2] = '{0, 0};

    function automatic logic oh(input logic [1:0] x);
        return (x == 2'b01) || (x == 2'b10);
    endfunction
    function automatic logic [1:0] rail(input logic v);
        return v ? 2'b10 : 2'b01;
    endfunction
    function automatic logic fsum(input logic a, input logic b, input logic c);
        return a ^ b ^ c;
    endfunction
    function automatic logic fcar(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 2; k++) begin
            if (in_valid && in_ready[k]) nbits[k] <= 0;
            if (fa_rst[k]) begin
                fa_s[k] <= 2'b00; fa_cout[k] <= 2'b00;
                la[k] <= 2'b00; lb[k] <= 2'b00; lc[k] <= 2'b00;
            end else if (k == 1) begin
                if (fa_en[k] && oh(fa_a[k] ^ la[k]) && oh(fa_b[k] ^ lb[k]) &&
                    oh(fa_cin[k] ^ lc[k]) && nbits[k] != stall_at[k]) begin
                    fa_s[k] <= fa_s[k] ^ rail(fsum((fa_a[k] ^ la[k]) == 2'b10,
                        (fa_b[k] ^ lb[k]) == 2'b10, (fa_cin[k] ^ lc[k]) == 2'b10));
                    fa_cout[k] <= fa_cout[k] ^ rail(fcar((fa_a[k] ^ la[k]) == 2'b10,
                        (fa_b[k] ^ lb[k]) == 2'b10, (fa_cin[k] ^ lc[k]) == 2'b10));
                    la[k] <= fa_a[k]; lb[k] <= fa_b[k]; lc[k] <= fa_cin[k];
                    nbits[k] <= nbits[k] + 1;
                end
            end else begin
                if (fa_a[k] == 2'b00 && fa_b[k] == 2'b00 && fa_cin[k] == 2'b00) begin
                    fa_s[k] <= 2'b00; fa_cout[k] <= 2'b00;
                end else if (fa_en[k] && oh(fa_a[k]) && oh(fa_b[k]) && oh(fa_cin[k]) &&
                             fa_s[k] == 2'b00 && fa_cout[k] == 2'b00 &&
                             nbits[k] != stall_at[k]) begin
                    fa_s[k]    <= bad11[k] ? 2'b11 : rail(fsum(fa_a[k][1], fa_b[k][1], fa_cin[k][1]));
                    fa_cout[k] <= rail(fcar(fa_a[k][1], fa_b[k][1], fa_cin[k][1]));
                    nbits[k]   <= nbits[k] + 1;
                end
            end
            en_prev[k] <= fa_en[k];
            en_run[k]  <= fa_en[k] ? en_run[k] + 1 : 0;
            if (fa_en[k] && !en_prev[k]) en_pulses[k] <= en_pulses[k] + 1;
            if (!fa_en[k] && en_prev[k]) begin
                fall_cyc[k] <= cyc;
                if (en_run[k] != EN_CYC) en_bad[k] <= en_bad[k] + 1;
            end
            if (fa_rst[k]) rst_hi[k] <= rst_hi[k] + 1;
            ov_prev[k] <= out_valid[k];
            if (out_valid[k] && !ov_prev[k]) ov_cyc[k] <= cyc;
        end
    end

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    logic [WIDTH-1:0] cap_sum [2];
    logic             cap_cout [2], cap_err [2], got [2];

    task automatic wait_idle();
        for (int n = 0; n < 200 && !(in_ready[0] && in_ready[1]); n++) @(negedge clk);
        chk("both_idle", {31'd0, in_ready[0] & in_ready[1]}, 1);
    endtask

    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic ci);
        wait_idle();
        op_a = a; op_b = b; c_in = ci; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic ci);
        start_op(a, b, ci);
        got[0] = 1'b0; got[1] = 1'b0;
        for (int n = 0; n < 400 && !(got[0] && got[1]); n++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (!got[k] && out_valid[k]) begin
                    got[k] = 1'b1; cap_sum[k] = sum[k]; cap_cout[k] = c_out[k]; cap_err[k] = err[k];
                end
            end
        end
        for (int k = 0; k < 2; k++) chk($sformatf("done_%0d", k), {31'd0, got[k]}, 1);
    endtask

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             ci;
        logic [WIDTH-1:0] s;
        logic             co;
    } vec_t;

    vec_t vecs [7];
    int   p_en [2], p_bad [2], p_rst [2];
    logic stable [2];
    logic ov_seen;
    logic found;

    initial begin
        vecs[0] = '{4'h3, 4'h5, 1'b0, 4'h8, 1'b0};
        vecs[1] = '{4'hF, 4'h1, 1'b0, 4'h0, 1'b1};
        vecs[2] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1};
        vecs[3] = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0};
        vecs[4] = '{4'hA, 4'h5, 1'b1, 4'h0, 1'b1};
        vecs[5] = '{4'h6, 4'h3, 1'b1, 4'hA, 1'b0};
        vecs[6] = '{4'h9, 4'h4, 1'b0, 4'hD, 1'b0};

        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_in_ready_%0d", k),  {31'd0, in_ready[k]}, 0);
            chk($sformatf("rst_fa_rst_%0d", k),    {31'd0, fa_rst[k]}, 1);
            chk($sformatf("rst_out_valid_%0d", k), {31'd0, out_valid[k]}, 0);
            chk($sformatf("rst_sum_%0d", k),       {28'd0, sum[k]}, 0);
            chk($sformatf("rst_fa_en_a_%0d", k),   {29'd0, fa_en[k], fa_a[k]}, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("post_rst_fa_rst_%0d", k),   {31'd0, fa_rst[k]}, 0);
            chk($sformatf("post_rst_in_ready_%0d", k), {31'd0, in_ready[k]}, 1);
        end

        foreach (vecs[i]) begin
            for (int k = 0; k < 2; k++) begin p_en[k] = en_pulses[k]; p_bad[k] = en_bad[k]; end
            run_op(vecs[i].a, vecs[i].b, vecs[i].ci);
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("v%0d_sum_%0d", i, k),  {28'd0, cap_sum[k]}, {28'd0, vecs[i].s});
                chk($sformatf("v%0d_cout_%0d", i, k), {31'd0, cap_cout[k]}, {31'd0, vecs[i].co});
                chk($sformatf("v%0d_err_%0d", i, k),  {31'd0, cap_err[k]}, 0);
                chk($sformatf("v%0d_en_pulses_%0d", i, k), en_pulses[k] - p_en[k], 4);
                chk($sformatf("v%0d_en_len_bad_%0d", i, k), en_bad[k] - p_bad[k], 0);
            end
        end

        // Cell stalls on bit 2: E+5 keeps only bits 0 and 1 (0011)
        stall_at[0] = 2; stall_at[1] = 2;
        for (int k = 0; k < 2; k++) p_rst[k] = rst_hi[k];
        run_op(4'hE, 4'h5, 1'b0);
        repeat (2) @(negedge clk);
        stall_at[0] = -1; stall_at[1] = -1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("tmo_err_%0d", k),  {31'd0, cap_err[k]}, 1);
            chk($sformatf("tmo_sum_%0d", k),  {28'd0, cap_sum[k]}, 4'h3);
            chk($sformatf("tmo_cout_%0d", k), {31'd0, cap_cout[k]}, 0);
            chk($sformatf("tmo_fa_rst_cycles_%0d", k), rst_hi[k] - p_rst[k], 1);
            chk($sformatf("tmo_wait_ok_%0d (gap %0d)", k, ov_cyc[k] - fall_cyc[k]),
                {31'd0, (ov_cyc[k] - fall_cyc[k] >= TIMEOUT) && (ov_cyc[k] - fall_cyc[k] <= TIMEOUT + 1)}, 1);
        end

        // FP cell emits an illegal 11 sum
        bad11[0] = 1'b1;
        run_op(4'h3, 4'h5, 1'b0);
        repeat (2) @(negedge clk);
        bad11[0] = 1'b0;
        chk("bad11_err_fp",  {31'd0, cap_err[0]}, 1);
        chk("bad11_sum_fp",  {28'd0, cap_sum[0]}, 0);
        chk("bad11_fast_fp", {31'd0, (ov_cyc[0] - fall_cyc[0]) < TIMEOUT}, 1);
        chk("bad11_tp_sum",  {28'd0, cap_sum[1]}, 4'h8);
        chk("bad11_tp_err_cleared", {31'd0, cap_err[1]}, 0);

        // Consumer back-pressure in DONE
        out_ready = 1'b0;
        run_op(4'h6, 4'h3, 1'b1);
        stable[0] = 1'b1; stable[1] = 1'b1;
        repeat (10) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++)
                if (sum[k] !== cap_sum[k] || c_out[k] !== cap_cout[k] ||
                    out_valid[k] !== 1'b1 || in_ready[k] !== 1'b0) stable[k] = 1'b0;
        end
        out_ready = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("hold_stable_%0d", k), {31'd0, stable[k]}, 1);
            chk($sformatf("hold_sum_%0d", k), {28'd0, cap_sum[k]}, 4'hA);
            chk($sformatf("hold_release_ov_%0d", k), {31'd0, out_valid[k]}, 0);
            chk($sformatf("hold_release_rdy_%0d", k), {31'd0, in_ready[k]}, 1);
        end

        // Reset while the FP instance is in EN_HI of bit 1
        p_en[0] = en_pulses[0];
        start_op(4'h3, 4'h5, 1'b0);
        found = 1'b0;
        for (int n = 0; n < 200 && !found; n++) begin
            if (en_pulses[0] - p_en[0] == 2 && fa_en[0]) found = 1'b1;
            else @(negedge clk);
        end
        chk("rst_mid_en_hi_reached", {31'd0, found}, 1);
        ov_seen = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_fa_en",  {31'd0, fa_en[0]}, 0);
        chk("mid_rst_fa_a",   {30'd0, fa_a[0]}, 0);
        chk("mid_rst_fa_rst", {31'd0, fa_rst[0]}, 1);
        chk("mid_rst_tp_fa_rst", {31'd0, fa_rst[1]}, 1);
        ov_seen = ov_seen | out_valid[0] | out_valid[1];
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            ov_seen = ov_seen | out_valid[0] | out_valid[1];
        end
        chk("mid_rst_no_out_valid", {31'd0, ov_seen}, 0);
        run_op(4'h1, 4'h1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("after_rst_sum_%0d", k),  {28'd0, cap_sum[k]}, 4'h2);
            chk($sformatf("after_rst_cout_%0d", k), {31'd0, cap_cout[k]}, 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
